// File: rtl/ring_sweep_master.sv
// Purpose: Wishbone initiator running 2^N reset/run/stop/read ring-oscillator samples and summing the counts.
// Latency: 13+G cycles per sample with a 1-cycle-ack slave; done_o one cycle after the last sample.
// Backpressure: each transfer holds until wbm_ack_i; define RING_SWEEP_TIMEOUT_EN for an ack watchdog.
module ring_sweep_master #(
    parameter logic [31:0] SLAVE_BASE     = 32'h3000_0000,
    parameter int          CLKMUX_BITS    = 3,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic                   wb_clk_i,
    input  logic                   resetb,
    input  logic                   start_i,
    input  logic [15:0]            gate_cycles_i,
    input  logic [2:0]             avg_log2_i,
    input  logic [CLKMUX_BITS-1:0] clkmux_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   error_o,
    output logic [20:0]            sum_o,
    output logic                   wbm_cyc_o,
    output logic                   wbm_stb_o,
    output logic                   wbm_we_o,
    output logic [3:0]             wbm_sel_o,
    output logic [31:0]            wbm_adr_o,
    output logic [31:0]            wbm_dat_o,
    input  logic [31:0]            wbm_dat_i,
    input  logic                   wbm_ack_i
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_W_RST  = 3'd1;
    localparam logic [2:0] S_W_RUN  = 3'd2;
    localparam logic [2:0] S_GATE   = 3'd3;
    localparam logic [2:0] S_W_STOP = 3'd4;
    localparam logic [2:0] S_RD     = 3'd5;
    localparam logic [2:0] S_NEXT   = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    localparam logic [1:0] CTL_STOP = 2'd0;
    localparam logic [1:0] CTL_RST  = 2'd1;
    localparam logic [1:0] CTL_RUN  = 2'd2;

    logic [2:0]             state;
    logic                   xfer_done;
    logic [15:0]            gate_len;
    logic [15:0]            gate_cnt;
    logic [2:0]             avg_q;
    logic [CLKMUX_BITS-1:0] mux_q;
    logic [3:0]             sample_cnt;
    logic [20:0]            sum_q;
    logic                   cyc_q;
    logic                   we_q;
    logic [31:0]            adr_q;
    logic [31:0]            dat_q;

    logic                   ack_seen;
    logic                   timeout;
    logic                   last_sample;
    logic                   gate_last;
    logic                   issue;
    logic                   issue_we;
    logic [1:0]             issue_code;
    logic [CLKMUX_BITS-1:0] issue_mux;
    logic [31:0]            issue_ctl;

    assign ack_seen    = cyc_q & wbm_ack_i;
    assign last_sample = ({1'b0, sample_cnt} == ((5'd1 << avg_q) - 5'd1));
    assign gate_last   = (gate_cnt == gate_len - 16'd1);

    // A transfer is issued on the same edge that leaves IDLE/GATE/NEXT or ends the post-ack idle slot.
    always_comb begin
        issue      = 1'b0;
        issue_we   = 1'b1;
        issue_code = CTL_STOP;
        issue_mux  = mux_q;
        case (state)
            S_IDLE: begin
                issue      = start_i;
                issue_code = CTL_RST;
                issue_mux  = clkmux_i;
            end
            S_W_RST: begin
                issue      = xfer_done;
                issue_code = CTL_RUN;
            end
            S_GATE: begin
                issue      = gate_last;
                issue_code = CTL_STOP;
            end
            S_W_STOP: begin
                issue    = xfer_done;
                issue_we = 1'b0;
            end
            S_NEXT: begin
                issue      = ~last_sample;
                issue_code = CTL_RST;
            end
            default: ;
        endcase
    end

    assign issue_ctl = {{(24-CLKMUX_BITS){1'b0}}, issue_mux, 6'b0, issue_code};

    always_ff @(posedge wb_clk_i or negedge resetb) begin
        if (!resetb) begin
            state      <= S_IDLE;
            xfer_done  <= 1'b0;
            gate_len   <= '0;
            gate_cnt   <= '0;
            avg_q      <= '0;
            mux_q      <= '0;
            sample_cnt <= '0;
            sum_q      <= '0;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
        end else begin
            if (issue) begin
                cyc_q <= 1'b1;
                we_q  <= issue_we;
                adr_q <= issue_we ? (SLAVE_BASE + 32'h4) : SLAVE_BASE;
                dat_q <= issue_we ? issue_ctl : 32'h0;
            end else if (ack_seen || timeout) begin
                cyc_q <= 1'b0;
                we_q  <= 1'b0;
                adr_q <= '0;
                dat_q <= '0;
            end

            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        gate_len   <= (gate_cycles_i == 16'd0) ? 16'd1 : gate_cycles_i;
                        avg_q      <= (avg_log2_i > 3'd4) ? 3'd4 : avg_log2_i;
                        mux_q      <= clkmux_i;
                        sum_q      <= '0;
                        sample_cnt <= '0;
                        state      <= S_W_RST;
                    end
                end
                S_W_RST, S_W_RUN, S_W_STOP, S_RD: begin
                    if (timeout) begin
                        sum_q <= '0;
                        state <= S_DONE;
                    end else if (ack_seen) begin
                        xfer_done <= 1'b1;
                        if (state == S_RD)
                            sum_q <= sum_q + {4'd0, wbm_dat_i[16:0]};
                    end else if (xfer_done) begin
                        xfer_done <= 1'b0;
                        case (state)
                            S_W_RST:  state <= S_W_RUN;
                            S_W_RUN: begin
                                state    <= S_GATE;
                                gate_cnt <= '0;
                            end
                            S_W_STOP: state <= S_RD;
                            default:  state <= S_NEXT;
                        endcase
                    end
                end
                S_GATE: begin
                    gate_cnt <= gate_cnt + 16'd1;
                    if (gate_last)
                        state <= S_W_STOP;
                end
                S_NEXT: begin
                    if (last_sample) begin
                        state <= S_DONE;
                    end else begin
                        sample_cnt <= sample_cnt + 4'd1;
                        state      <= S_W_RST;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef RING_SWEEP_TIMEOUT_EN
    logic [7:0] wdog;
    logic       error_q;

    assign timeout = cyc_q & ~wbm_ack_i & (wdog == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge wb_clk_i or negedge resetb) begin
        if (!resetb) begin
            wdog    <= '0;
            error_q <= 1'b0;
        end else begin
            wdog <= (cyc_q & ~wbm_ack_i & ~timeout) ? wdog + 8'd1 : 8'd0;
            if (state == S_IDLE && start_i)
                error_q <= 1'b0;
            else if (timeout)
                error_q <= 1'b1;
        end
    end

    assign error_o = error_q;
`else
    logic unused_tmo;

    assign timeout    = 1'b0;
    assign error_o    = 1'b0;
    assign unused_tmo = (TIMEOUT_CYCLES == 0);
`endif

    logic unused_dat;
    assign unused_dat = ^wbm_dat_i[31:17];

    assign busy_o    = (state != S_IDLE) && (state != S_DONE);
    assign done_o    = (state == S_DONE);
    assign sum_o     = sum_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = {4{cyc_q}};
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;

endmodule
